// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock, LSB first,
// with a start/busy/done handshake around a single full-subtractor cell.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bor_q, bor_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic ai, bi, bin, d, bout, last;

    // Full-subtractor cell on the current LSBs and the registered borrow.
    assign ai   = a_sh_q[0];
    assign bi   = b_sh_q[0];
    assign bin  = bor_q;
    assign d    = ai ^ bi ^ bin;
    assign bout = (~ai & bi) | (~(ai ^ bi) & bin);
    assign last = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    always_comb begin
        a_sh_d = a_sh_q;
        b_sh_d = b_sh_q;
        res_d  = res_q;
        bor_d  = bor_q;
        cnt_d  = cnt_q;
        diff_d = diff_q;
        bout_d = bout_q;
        if (state_q == IDLE && start) begin
            a_sh_d = a;
            b_sh_d = b;
            bor_d  = 1'b0;
            cnt_d  = '0;
        end else if (state_q == RUN) begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            res_d  = {d, res_q[WIDTH-1:1]};
            bor_d  = bout;
            cnt_d  = cnt_q + 1'b1;
            // Publish only the completed word so diff never shows partial bits.
            if (last) begin
                diff_d = {d, res_q[WIDTH-1:1]};
                bout_d = bout;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_q <= '0;
            b_sh_q <= '0;
            res_q  <= '0;
            bor_q  <= 1'b0;
            cnt_q  <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else begin
            a_sh_q <= a_sh_d;
            b_sh_q <= b_sh_d;
            res_q  <= res_d;
            bor_q  <= bor_d;
            cnt_q  <= cnt_d;
            diff_q <= diff_d;
            bout_q <= bout_d;
        end
    end

    assign diff       = diff_q;
    assign borrow_out = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): expected {borrow,diff}
// queued at issue, popped and compared on each done pulse.
module tb_serial_subtractor;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic [W-1:0] diff;
    logic         borrow_out, busy, done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [W:0] sb[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .diff(diff), .borrow_out(borrow_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
        return {1'b0, x} - {1'b0, y};
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            if (sb.size() == 0) chk("sb_empty_on_done", 1, 0);
            else begin
                logic [W:0] e;
                e = sb.pop_front();
                chk("diff", {24'd0, diff}, {24'd0, e[W-1:0]});
                chk("borrow_out", {31'd0, borrow_out}, {31'd0, e[W]});
            end
        end
    end

    // One operation with start pulsed for one cycle; inj marks cycles where a
    // stray start with other operands is raised while busy.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [15:0] inj);
        int k, busy_cycles, d0;
        bit seen;
        d0 = done_cnt;
        start = 1'b1; a = av; b = bv;
        sb.push_back(model(av, bv));
        @(posedge clk); #1;
        start = 1'b0; a = W'($urandom); b = W'($urandom);
        k = 0; seen = 0; busy_cycles = busy ? 1 : 0;
        while (!seen && k < 20) begin
            @(posedge clk); #1;
            k++;
            start = inj[k];
            if (inj[k]) begin a = 8'd5; b = 8'd9; end
            if (busy) busy_cycles++;
            if (done) seen = 1;
        end
        chk("done_seen", {31'd0, seen}, 1);
        chk("done_latency", k, W);
        chk("busy_cycles", busy_cycles, W + 1);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_idle", {31'd0, busy}, 0);
        chk("done_once", done_cnt - d0, 1);
    endtask

    initial begin
        logic [W-1:0] ta[4];
        logic [W-1:0] tbv[4];
        logic [W:0]   prev;
        int d0;

        #2;
        chk("rst_diff", {24'd0, diff}, 0);
        chk("rst_bor", {31'd0, borrow_out}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        do_op(8'd100, 8'd37, '0);
        chk("hold_after_done", {24'd0, diff}, 32'h3F);
        do_op(8'd37, 8'd100, '0);
        do_op(8'd0, 8'd1, '0);
        do_op(8'd255, 8'd255, '0);
        do_op(8'd255, 8'd0, '0);
        do_op(8'd100, 8'd37, 16'h0108);

        // Asynchronous reset in the middle of a run.
        d0 = done_cnt;
        start = 1'b1; a = 8'd100; b = 8'd37;
        sb.push_back(model(8'd100, 8'd37));
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_diff", {24'd0, diff}, 0);
        chk("arst_bor", {31'd0, borrow_out}, 0);
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_done", {31'd0, done}, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("arst_no_done", done_cnt - d0, 0);
        chk("arst_still_idle", {31'd0, busy}, 0);
        do_op(8'd10, 8'd3, '0);

        // Back-to-back with start held high.
        ta[0] = 8'd200; tbv[0] = 8'd1;
        ta[1] = 8'd3;   tbv[1] = 8'd4;
        ta[2] = 8'd128; tbv[2] = 8'd128;
        ta[3] = 8'd77;  tbv[3] = 8'd12;
        prev = model(8'd10, 8'd3);
        start = 1'b1;
        for (int j = 0; j < 4; j++) begin
            a = ta[j]; b = tbv[j];
            sb.push_back(model(ta[j], tbv[j]));
            @(posedge clk); #1;
            chk("b2b_accept", {31'd0, busy}, 1);
            for (int k = 1; k <= W + 1; k++) begin
                @(posedge clk); #1;
                if (k == 4) chk("b2b_hold", {23'd0, borrow_out, diff}, {23'd0, prev});
                if (k == W + 1) chk("b2b_idle", {31'd0, busy}, 0);
            end
            prev = model(ta[j], tbv[j]);
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        chk("b2b_last_diff", {24'd0, diff}, 32'd65);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got=1 exp=0");
        $fatal(1, "timeout");
    end
endmodule
